mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 32-bit 4:1 datapath mux between four requesters.

---
 rtl/muxarb_pkg.sv | 33 +++
 rtl/rr_pick.sv | 27 ++
 rtl/mux_rr_arbiter.sv | 119 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muxarb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
// Holds requester/select sizing, the FSM state encoding and one-hot/index helpers.
package muxarb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Turn a requester index into its one-hot grant vector.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Recover the index from a one-hot vector (all-zero maps to index 0).
    function automatic logic [SEL_W-1:0] onehot2idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder for the round-robin arbiter.
// Finds the first set request bit scanning upward from ptr, wrapping modulo N_REQ.
module rr_pick
    import muxarb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset back to ptr so the closest set request wins.
    always_comb begin
        found = |req;
        idx   = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning a shared 32-bit 4:1 datapath mux.
// Grants one requester at a time, holds the mux until its burst ends, abandons,
// or (with MUXARB_HOLD_LIMIT_EN defined) reaches MAX_HOLD accepted beats.
// Every release spends one IDLE cycle before the next grant.
module mux_rr_arbiter
    import muxarb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] last,
    input  logic             bus_ready,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             bus_valid,
    output logic             busy
);

    localparam logic ST_IDLE  = ARB_IDLE;
    localparam logic ST_GRANT = ARB_GRANT;

`ifdef MUXARB_HOLD_LIMIT_EN
    localparam bit hold_limit_en = 1'b1;
`else
    localparam bit hold_limit_en = 1'b0;
`endif

    logic             state;
    logic             state_nxt;
    logic [SEL_W-1:0] owner;
    logic [SEL_W-1:0] owner_nxt;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_ptr_nxt;
    logic [SEL_W-1:0] sel_nxt;
    logic [N_REQ-1:0] grant_nxt;
    logic [3:0]       beat_cnt;
    logic [3:0]       beat_cnt_nxt;
    logic [3:0]       beat_inc;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;
    logic             owner_last;
    logic             accept;
    logic             hold_reached;
    logic             release_now;

    rr_pick u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign owner_req    = req[owner];
    assign owner_last   = last[owner];
    assign accept       = (state == ST_GRANT) && owner_req && bus_ready;
    assign beat_inc     = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;
    assign hold_reached = hold_limit_en && (beat_inc == 4'(MAX_HOLD));

    assign busy      = (state == ST_GRANT);
    assign bus_valid = (state == ST_GRANT) && owner_req;

    // Decide the next owner, pointer and beat count from the current state and owner inputs.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_ptr_nxt   = rr_ptr;
        sel_nxt      = sel;
        grant_nxt    = grant;
        beat_cnt_nxt = beat_cnt;
        release_now  = 1'b0;

        if (state == ST_IDLE) begin
            if (pick_found) begin
                state_nxt    = ST_GRANT;
                owner_nxt    = pick_idx;
                sel_nxt      = pick_idx;
                grant_nxt    = idx2onehot(pick_idx);
                beat_cnt_nxt = 4'd0;
            end
        end else begin
            release_now = !owner_req
                        || (accept && owner_last)
                        || (accept && hold_reached);
            if (release_now) begin
                state_nxt    = ST_IDLE;
                grant_nxt    = '0;
                beat_cnt_nxt = 4'd0;
                rr_ptr_nxt   = owner + SEL_W'(1);
            end else if (accept) begin
                beat_cnt_nxt = beat_inc;
            end
        end
    end

    // Register arbiter state; reset drops the grant immediately and restores idle defaults.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter.
// Directed scenarios plus randomized traffic compared to a behavioural model.
// Build with MUXARB_HOLD_LIMIT_EN defined to exercise the beat limit.
module tb_mux_rr_arbiter;
    import muxarb_pkg::*;

    localparam int MAX_HOLD = 8;
`ifdef MUXARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] last;
    logic       bus_ready;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       bus_valid;
    logic       busy;

    int checks;
    int failures;
    int obs_beats;

    int m_owner;
    int m_ptr;
    int m_beats;
    int m_sel;

    mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .last      (last),
        .bus_ready (bus_ready),
        .sel       (sel),
        .grant     (grant),
        .bus_valid (bus_valid),
        .busy      (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge.
    task automatic model_advance(input logic [3:0] r, input logic [3:0] l, input logic b);
        bit rel;
        rel = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    m_sel   = m_owner;
                    m_beats = 0;
                end
            end
        end else begin
            if (!r[m_owner]) begin
                rel = 1'b1;
            end else if (b) begin
                m_beats = (m_beats < 15) ? m_beats + 1 : 15;
                if (l[m_owner]) rel = 1'b1;
                else if (HOLD_EN && m_beats == MAX_HOLD) rel = 1'b1;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_beats = 0;
            end
        end
    endtask

    function automatic logic [3:0] exp_grant();
        return (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    endfunction

    // Apply inputs, note an accepted beat, step the model, then move past the next edge.
    task automatic drive_cycle(input logic [3:0] r, input logic [3:0] l, input logic b);
        req       = r;
        last      = l;
        bus_ready = b;
        #1;
        if (bus_valid && bus_ready) obs_beats++;
        model_advance(r, l, b);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        bus_ready = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        obs_beats = 0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req       = 4'b1111;
        last      = 4'b0000;
        bus_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        checks++;
        if (sel !== 2'd0) begin failures++; $display("[TB] FAIL reset_sel got %0d want 0", sel); end
        checks++;
        if (busy !== 1'b0 || bus_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy busy=%b valid=%b want 0 0", busy, bus_valid); end
        reset_n = 1'b1;
        model_reset();
        obs_beats = 0;
        drive_cycle(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin failures++; $display("[TB] FAIL reset_first_grant got %b busy=%b want 0001 1", grant, busy); end
        drive_cycle(4'b1111, 4'b0001, 1'b1);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_release got %b busy=%b want 0000 0", grant, busy); end
        drive_cycle(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b0010 || sel !== 2'd1) begin failures++; $display("[TB] FAIL reset_ptr_next got %b sel=%0d want 0010 1", grant, sel); end
    endtask

    task automatic test_rotation();
        logic [3:0] order [5];
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            drive_cycle(4'b1111, 4'b0000, 1'b1);
            checks++;
            if (grant !== order[k] || bus_valid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL rotation_grant step %0d got %b valid=%b want %b 1", k, grant, bus_valid, order[k]);
            end
            drive_cycle(4'b1111, 4'b1111, 1'b1);
            checks++;
            if (grant !== 4'b0000 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL rotation_idle step %0d got %b busy=%b want 0000 0", k, grant, busy);
            end
        end
    endtask

    task automatic test_stall_burst();
        logic       rdy [5];
        logic [3:0] lst [5];
        rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        lst = '{4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b1111};
        apply_reset();
        drive_cycle(4'b0100, 4'b0000, 1'b0);
        obs_beats = 0;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(4'b0100, lst[k], rdy[k]);
            if (k < 4) begin
                checks++;
                if (sel !== 2'd2 || grant !== 4'b0100) begin
                    failures++;
                    $display("[TB] FAIL stall_hold step %0d sel=%0d grant=%b want 2 0100", k, sel, grant);
                end
            end
        end
        checks++;
        if (grant !== 4'b0000 || sel !== 2'd2) begin failures++; $display("[TB] FAIL stall_release grant=%b sel=%0d want 0000 2", grant, sel); end
        checks++;
        if (obs_beats != 3) begin failures++; $display("[TB] FAIL stall_beats got %0d want 3", obs_beats); end
    endtask

    task automatic test_abandon();
        apply_reset();
        drive_cycle(4'b0010, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL abandon_grant got %b want 0010", grant); end
        drive_cycle(4'b1010, 4'b0000, 1'b1);
        checks++;
        if (grant !== 4'b0010) begin failures++; $display("[TB] FAIL abandon_midburst got %b want 0010", grant); end
        drive_cycle(4'b1000, 4'b0000, 1'b1);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL abandon_idle got %b busy=%b want 0000 0", grant, busy); end
        drive_cycle(4'b1000, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b1000 || sel !== 2'd3) begin failures++; $display("[TB] FAIL abandon_next got %b sel=%0d want 1000 3", grant, sel); end
    endtask

    task automatic test_hold_limit();
        apply_reset();
        drive_cycle(4'b0001, 4'b0000, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            drive_cycle(4'b0001, 4'b0000, 1'b1);
            checks++;
            if (grant !== exp_grant()) begin
                failures++;
                $display("[TB] FAIL hold_model beat %0d got %b want %b", k, grant, exp_grant());
            end
            if (HOLD_EN && k == MAX_HOLD) begin
                checks++;
                if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL hold_limit beat %0d got %b want 0000", k, grant); end
            end
            if (!HOLD_EN) begin
                checks++;
                if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL hold_persist beat %0d got %b want 0001", k, grant); end
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive_cycle(4'b0100, 4'b0000, 1'b0);
        drive_cycle(4'b0100, 4'b0000, 1'b1);
        checks++;
        if (grant !== 4'b0100 || bus_valid !== 1'b1) begin failures++; $display("[TB] FAIL async_pre grant=%b valid=%b want 0100 1", grant, bus_valid); end
        reset_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0000 || bus_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL async_drop grant=%b valid=%b busy=%b want 0000 0 0", grant, bus_valid, busy);
        end
        checks++;
        if (sel !== 2'd0) begin failures++; $display("[TB] FAIL async_sel got %0d want 0", sel); end
        #1;
        reset_n = 1'b1;
        model_reset();
        drive_cycle(4'b1111, 4'b0000, 1'b0);
        checks++;
        if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL async_ptr got %b want 0001", grant); end
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] l;
        logic       b;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 9) != 0) r[m_owner] = 1'b1;
            l = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            b = 1'($urandom);
            drive_cycle(r, l, b);
            checks++;
            if (grant !== exp_grant() || sel !== 2'(m_sel) || busy !== (m_owner >= 0)) begin
                failures++;
                $display("[TB] FAIL rand_state cycle %0d grant=%b sel=%0d busy=%b want %b %0d %b",
                         c, grant, sel, busy, exp_grant(), m_sel, (m_owner >= 0));
            end
            checks++;
            if (bus_valid !== (m_owner >= 0 && r[m_owner])) begin
                failures++;
                $display("[TB] FAIL rand_valid cycle %0d got %b want %b", c, bus_valid, (m_owner >= 0 && r[m_owner]));
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks    = 0;
        failures  = 0;
        obs_beats = 0;
        reset_n   = 1'b0;
        req       = 4'b0000;
        last      = 4'b0000;
        bus_ready = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_stall_burst();
        test_abandon();
        test_hold_limit();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
